turn_score_tracker: RTL and testbench
=====================================

Name: turn_score_tracker

Overview:
- Parametrised successor to the fixed 4-player count-select mux.
- Holds per-player step counters, owns the turn pointer, and rotates turns over a runtime-selected player count.
- Presents the current and next player's counts to the display path, detects the winner, and freezes play.
- Sits between the input/debounce logic and the score/seven-segment display logic.

Parameters:
- MAX_PLAYERS, 4, maximum number of players supported (>=2).
- CNT_W, 5, width of each player counter.
- WIN_CNT, 24, count value that ends the game (1..2^CNT_W-1).
- PID_W, $clog2(MAX_PLAYERS), width of player index fields (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new game from any state
- num_players_m1  in  PID_W  player count minus 1, sampled on start
- score_inc  in  1  one-cycle pulse; +1 to the current player
- score_dec  in  1  one-cycle pulse; -1 to the current player
- turn_end  in  1  one-cycle pulse; pass the turn to the next player
- playing  out  1  high in PLAY
- game_over  out  1  high in OVER
- turn  out  PID_W  index of the current player
- winner  out  PID_W  index of the winning player; valid while game_over
- cur_cnt  out  CNT_W  current player's count
- next_cnt  out  CNT_W  count of the next player in rotation
- cnt_bus  out  MAX_PLAYERS*CNT_W  all counters; player i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all counters=0; turn=0; winner=0; active player count register=1 (two players).
  - Outputs: playing=0, game_over=0, cur_cnt=0, next_cnt=0, cnt_bus=0.
- States: IDLE, PLAY, OVER.
  - IDLE->PLAY on start.
  - PLAY->OVER when an increment makes the current player's count equal WIN_CNT.
  - OVER->PLAY on start.
  - There is no path back to IDLE except reset.
- start (any state), applied at the next clock edge:
  - Clears all counters, turn=0, winner=0.
  - Latches num_players_m1. A value of 0 is coerced to 1, so there are never fewer than two players.
  - start has priority; score_inc, score_dec and turn_end in the same cycle are ignored.
- In IDLE and OVER, score_inc, score_dec and turn_end are ignored. Counters, turn and winner hold.
- PLAY scoring (counter of the current player = turn):
  - inc only: +1, saturating at 2^CNT_W-1.
  - dec only: -1, saturating at 0.
  - inc and dec together: no change.
- Win detection:
  - Evaluated on the post-update value of an increment only.
  - When it equals WIN_CNT: winner=turn, state=OVER, turn holds.
- turn_end in PLAY:
  - turn = (turn == active_m1) ? 0 : turn+1.
  - Wrap is at the latched player count, not at MAX_PLAYERS.
- turn_end with a scoring pulse in the same cycle:
  - The score applies to the outgoing player; turn then advances.
  - If that score wins, the win takes priority: turn holds and OVER is entered.
- cur_cnt, next_cnt, playing and game_over are combinational decodes of registered state. Latency is one clock from pulse to visible change.
- next_cnt = counter[(turn == active_m1) ? 0 : turn+1]. With two players, next_cnt is the other player's count.
- Counters of players with index > active_m1 stay 0 for the whole game.
- Inputs are single-cycle pulses. A pulse held high N cycles counts as N events; edge detection is the caller's job.

Test Plan:
- Reset, then start with num_players_m1=2; pulse turn_end 4x -> turn 0,1,2,0,1; next_cnt tracks player (turn+1)%3.
- Player 0: 3x score_inc then 1x score_dec -> cnt_bus[4:0]=2 and cur_cnt=2 one cycle after the last pulse. Then score_dec 3x -> saturates at 0.
- score_inc and turn_end in the same cycle with turn=1 and 3 players -> counter1 +1, turn=2. score_inc and score_dec together -> no change.
- Drive player 1 to WIN_CNT-1, then score_inc and turn_end together:
  - Required: game_over=1, winner=1, turn stays 1.
  - Further score and turn_end pulses are ignored.
  - start then clears all counters and sets playing=1.
- start with num_players_m1=0 -> two-player game; turn_end toggles turn 0/1 only.
- Assert rst_n low mid-game (async, between clock edges) -> all outputs 0 immediately, state IDLE; score pulses are ignored until start.

Source files
------------

// File: rtl/turn_score_tracker.sv
// rtl/turn_score_tracker.sv - per-player step counters, turn rotation and winner detection
module turn_score_tracker #(
    parameter int MAX_PLAYERS = 4,
    parameter int CNT_W       = 5,
    parameter int WIN_CNT     = 24,
    parameter int PID_W       = $clog2(MAX_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PID_W-1:0]             num_players_m1,
    input  logic                         score_inc,
    input  logic                         score_dec,
    input  logic                         turn_end,
    output logic                         playing,
    output logic                         game_over,
    output logic [PID_W-1:0]             turn,
    output logic [PID_W-1:0]             winner,
    output logic [CNT_W-1:0]             cur_cnt,
    output logic [CNT_W-1:0]             next_cnt,
    output logic [MAX_PLAYERS*CNT_W-1:0] cnt_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(WIN_CNT);
    localparam bit               PID_FULL = (MAX_PLAYERS == (1 << PID_W));

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [MAX_PLAYERS];
    logic [PID_W-1:0] turn_q;
    logic [PID_W-1:0] winner_q;
    logic [PID_W-1:0] active_m1_q;

    logic [PID_W-1:0] active_m1_d;
    logic [PID_W-1:0] next_idx;
    logic [CNT_W-1:0] score_d;
    logic             inc_only;
    logic             dec_only;
    logic             win_hit;

    // Player count latched on start: at least two players, never beyond the array
    always_comb begin
        active_m1_d = num_players_m1;
        if (num_players_m1 == '0) begin
            active_m1_d = PID_W'(1);
        end else if (!PID_FULL && (int'(num_players_m1) >= MAX_PLAYERS)) begin
            active_m1_d = PID_W'(MAX_PLAYERS - 1);
        end
    end

    // Next player in rotation and the saturating post-score value of the current player
    always_comb begin
        next_idx = (turn_q == active_m1_q) ? '0 : turn_q + PID_W'(1);
        inc_only = score_inc & ~score_dec;
        dec_only = score_dec & ~score_inc;
        score_d  = cnt_q[turn_q];
        if (inc_only && (cnt_q[turn_q] != CNT_MAX)) begin
            score_d = cnt_q[turn_q] + CNT_W'(1);
        end else if (dec_only && (cnt_q[turn_q] != '0)) begin
            score_d = cnt_q[turn_q] - CNT_W'(1);
        end
        win_hit = inc_only && (score_d == CNT_WIN);
    end

    // Game FSM: start restarts from any state; scoring and turn passing only while playing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            turn_q      <= '0;
            winner_q    <= '0;
            active_m1_q <= PID_W'(1);
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (start) begin
            state_q     <= S_PLAY;
            turn_q      <= '0;
            winner_q    <= '0;
            active_m1_q <= active_m1_d;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state_q == S_PLAY) begin
            cnt_q[turn_q] <= score_d;
            if (win_hit) begin
                // A winning score freezes the turn on the winner even if turn_end came with it
                winner_q <= turn_q;
                state_q  <= S_OVER;
            end else if (turn_end) begin
                turn_q <= next_idx;
            end
        end
    end

    // Display-side decodes of the registered state
    always_comb begin
        playing   = (state_q == S_PLAY);
        game_over = (state_q == S_OVER);
        turn      = turn_q;
        winner    = winner_q;
        cur_cnt   = cnt_q[turn_q];
        next_cnt  = cnt_q[next_idx];
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            cnt_bus[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_turn_score_tracker.sv
// tb/tb_turn_score_tracker.sv - randomized and directed bench for turn_score_tracker
module tb_turn_score_tracker;

    localparam int MAX_PLAYERS = 4;
    localparam int CNT_W       = 5;
    localparam int WIN_CNT     = 24;
    localparam int PID_W       = 2;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         start = 1'b0;
    logic [PID_W-1:0]             num_players_m1 = '0;
    logic                         score_inc = 1'b0;
    logic                         score_dec = 1'b0;
    logic                         turn_end = 1'b0;
    logic                         playing;
    logic                         game_over;
    logic [PID_W-1:0]             turn;
    logic [PID_W-1:0]             winner;
    logic [CNT_W-1:0]             cur_cnt;
    logic [CNT_W-1:0]             next_cnt;
    logic [MAX_PLAYERS*CNT_W-1:0] cnt_bus;

    int checks = 0;
    int errors = 0;
    int wins_seen = 0;

    // reference model: 0 idle, 1 play, 2 over
    int m_state;
    int m_cnt [MAX_PLAYERS];
    int m_turn;
    int m_winner;
    int m_players;

    turn_score_tracker #(
        .MAX_PLAYERS(MAX_PLAYERS),
        .CNT_W(CNT_W),
        .WIN_CNT(WIN_CNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_players_m1(num_players_m1),
        .score_inc(score_inc),
        .score_dec(score_dec),
        .turn_end(turn_end),
        .playing(playing),
        .game_over(game_over),
        .turn(turn),
        .winner(winner),
        .cur_cnt(cur_cnt),
        .next_cnt(next_cnt),
        .cnt_bus(cnt_bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_turn    = 0;
        m_winner  = 0;
        m_players = 2;
        for (int i = 0; i < MAX_PLAYERS; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input bit st, input int np_m1, input bit inc, input bit dec, input bit te);
        int v;
        if (st) begin
            for (int i = 0; i < MAX_PLAYERS; i++) m_cnt[i] = 0;
            m_turn    = 0;
            m_winner  = 0;
            m_players = (np_m1 < 1) ? 2 : np_m1 + 1;
            m_state   = 1;
            return;
        end
        if (m_state != 1) return;
        v = m_cnt[m_turn] + int'(inc) - int'(dec);
        if (v < 0) v = 0;
        if (v > CMAX) v = CMAX;
        m_cnt[m_turn] = v;
        if (inc && !dec && v == WIN_CNT) begin
            m_winner = m_turn;
            m_state  = 2;
            wins_seen++;
        end else if (te) begin
            m_turn = (m_turn + 1) % m_players;
        end
    endtask

    task automatic check_all(input string tag);
        logic [MAX_PLAYERS*CNT_W-1:0] eb;
        for (int i = 0; i < MAX_PLAYERS; i++) eb[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        check_eq({tag, ".playing"},   64'(playing),   64'(m_state == 1));
        check_eq({tag, ".game_over"}, 64'(game_over), 64'(m_state == 2));
        check_eq({tag, ".turn"},      64'(turn),      64'(m_turn));
        check_eq({tag, ".winner"},    64'(winner),    64'(m_winner));
        check_eq({tag, ".cur_cnt"},   64'(cur_cnt),   64'(m_cnt[m_turn]));
        check_eq({tag, ".next_cnt"},  64'(next_cnt),  64'(m_cnt[(m_turn + 1) % m_players]));
        check_eq({tag, ".cnt_bus"},   64'(cnt_bus),   64'(eb));
    endtask

    // one clock with the given pulses; outputs checked 1 time unit after the edge
    task automatic drive(input string tag, input bit st, input int np_m1, input bit inc, input bit dec, input bit te);
        start          = st;
        num_players_m1 = PID_W'(np_m1);
        score_inc      = inc;
        score_dec      = dec;
        turn_end       = te;
        @(posedge clk);
        model_step(st, np_m1, inc, dec, te);
        #1;
        start     = 1'b0;
        score_inc = 1'b0;
        score_dec = 1'b0;
        turn_end  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        check_eq("reset.playing_const", 64'(playing), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // pulses before start are ignored
        drive("idle_inc", 0, 0, 1, 0, 1);

        // three-player rotation
        drive("start3", 1, 2, 0, 0, 0);
        drive("rot1", 0, 0, 0, 0, 1);
        check_eq("rot1.turn_const", 64'(turn), 64'd1);
        drive("rot2", 0, 0, 0, 0, 1);
        check_eq("rot2.turn_const", 64'(turn), 64'd2);
        drive("rot3", 0, 0, 0, 0, 1);
        check_eq("rot3.turn_const", 64'(turn), 64'd0);
        drive("rot4", 0, 0, 0, 0, 1);
        check_eq("rot4.turn_const", 64'(turn), 64'd1);
        drive("rot5", 0, 0, 0, 0, 1);
        drive("rot6", 0, 0, 0, 0, 1);

        // player 0 scoring and saturation at zero
        for (int i = 0; i < 3; i++) drive("p0_inc", 0, 0, 1, 0, 0);
        drive("p0_dec", 0, 0, 0, 1, 0);
        check_eq("p0.cnt_const", 64'(cnt_bus[4:0]), 64'd2);
        check_eq("p0.cur_const", 64'(cur_cnt), 64'd2);
        for (int i = 0; i < 3; i++) drive("p0_sat0", 0, 0, 0, 1, 0);
        check_eq("p0.sat_const", 64'(cur_cnt), 64'd0);

        // score and turn_end together, then inc and dec together
        drive("to_p1", 0, 0, 0, 0, 1);
        drive("inc_te", 0, 0, 1, 0, 1);
        check_eq("inc_te.cnt1_const", 64'(cnt_bus[9:5]), 64'd1);
        check_eq("inc_te.turn_const", 64'(turn), 64'd2);
        drive("inc_dec", 0, 0, 1, 1, 0);
        check_eq("inc_dec.cnt2_const", 64'(cnt_bus[14:10]), 64'd0);

        // drive player 1 to WIN_CNT-1, then win together with turn_end
        drive("wrap0", 0, 0, 0, 0, 1);
        drive("wrap1", 0, 0, 0, 0, 1);
        for (int i = 0; i < WIN_CNT - 2; i++) drive("p1_climb", 0, 0, 1, 0, 0);
        check_eq("p1.pre_win_const", 64'(cur_cnt), 64'(WIN_CNT - 1));
        drive("win_te", 0, 0, 1, 0, 1);
        check_eq("win.game_over_const", 64'(game_over), 64'd1);
        check_eq("win.winner_const", 64'(winner), 64'd1);
        check_eq("win.turn_const", 64'(turn), 64'd1);
        drive("over_inc", 0, 0, 1, 0, 0);
        drive("over_dec", 0, 0, 0, 1, 1);
        drive("restart", 1, 2, 1, 0, 1);
        check_eq("restart.playing_const", 64'(playing), 64'd1);
        check_eq("restart.bus_const", 64'(cnt_bus), 64'd0);

        // player count of one is coerced to two
        drive("start_np0", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive("np0_rot", 0, 0, 0, 0, 1);
        check_eq("np0.turn_const", 64'(turn), 64'd0);

        // randomized play
        for (int n = 0; n < 3000; n++) begin
            bit st, inc, dec, te;
            st  = ($urandom_range(0, 99) < 2);
            inc = ($urandom_range(0, 99) < 55);
            dec = ($urandom_range(0, 99) < 15);
            te  = ($urandom_range(0, 99) < 12);
            drive("rand", st, int'($urandom_range(0, 3)), inc, dec, te);
        end

        // asynchronous reset between clock edges mid-game
        drive("pre_rst_start", 1, 3, 0, 0, 0);
        drive("pre_rst_inc", 0, 0, 1, 0, 1);
        drive("pre_rst_inc2", 0, 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check_eq("async_rst.bus_const", 64'(cnt_bus), 64'd0);
        #3;
        rst_n = 1'b1;
        drive("post_rst_inc", 0, 0, 1, 0, 1);
        drive("post_rst_start", 1, 1, 0, 0, 0);
        drive("post_rst_inc2", 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
